conv_stream: RTL

CONV_STREAM -- requirements
Module: conv_stream

---
 rtl/conv_stream.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/conv_stream.sv
// -----------------------------------------------------------------------------
// conv_stream
//   Full linear convolution of two K-element vectors, y[n] = sum_i a[i]*h[n-i]
//   for n = 0..2K-2, using one multiply-accumulate per clock. Each output
//   sample takes K MAC cycles and is presented for one cycle on y_out/y_idx
//   with y_valid. The datapath is AW bits wide, so it never overflows.
//
//   Handshake: start is a request that is only sampled in IDLE; it is
//   accepted at the edge where start=1 and the FSM is IDLE (and rst=0), and
//   operands/signed_mode are captured at that same edge. y_valid is a
//   one-cycle strobe with no back-pressure; y_out/y_idx hold between strobes.
//   done pulses for one cycle at the end of each job; busy covers the job
//   from the cycle after acceptance through the done cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any job)
//   start        job request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   a_vec        signal vector, element i at [i*DW +: DW]
//   h_vec        kernel vector, same packing
//   y_out        convolution sample y[y_idx]
//   y_idx        output index n
//   y_valid      one-cycle strobe qualifying y_out/y_idx
//   busy         job in progress
//   done         one-cycle end-of-job pulse
// -----------------------------------------------------------------------------
module conv_stream #(
    parameter  int DW = 9,
    parameter  int K  = 3,
    localparam int AW = 2 * DW + $clog2(K),
    localparam int IW = $clog2(2 * K - 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [K*DW-1:0] a_vec,
    input  logic [K*DW-1:0] h_vec,
    output logic [AW-1:0]   y_out,
    output logic [IW-1:0]   y_idx,
    output logic            y_valid,
    output logic            busy,
    output logic            done
);

    localparam int KW = $clog2(K);
    localparam logic [KW-1:0] I_LAST = KW'(K - 1);
    localparam logic [IW-1:0] N_LAST = IW'(2 * K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // state_q is the observation point for the FSM
    state_t state_q, state_d;

    logic [DW-1:0] a_q [K];
    logic [DW-1:0] a_d [K];
    logic [DW-1:0] h_q [K];
    logic [DW-1:0] h_d [K];
    logic          sgn_q, sgn_d;
    logic [KW-1:0] i_q, i_d;
    logic [IW-1:0] n_q, n_d;
    logic          fin_q, fin_d;      // last MAC issued; one drain cycle left in RUN
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] y_out_q, y_out_d;
    logic [IW-1:0] y_idx_q, y_idx_d;
    logic          y_valid_q, y_valid_d;

    logic          accept;
    logic [IW:0]   diff;
    logic          h_in_range;
    logic [KW-1:0] h_sel;
    logic [AW-1:0] a_ext, h_ext, prod, sum;

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] x, input logic s);
        return s ? {{(AW-DW){x[DW-1]}}, x} : {{(AW-DW){1'b0}}, x};
    endfunction

    assign accept = (state_q == S_IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (fin_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // ---------------- MAC term selection ----------------
    // h index is n-i; terms with n<i or n-i>=K contribute zero.
    always_comb begin
        diff       = {1'b0, n_q} - (IW + 1)'(i_q);
        h_in_range = !diff[IW] && (diff[IW-1:0] < IW'(K));
        h_sel      = diff[KW-1:0];
        a_ext      = ext(a_q[i_q], sgn_q);
        h_ext      = h_in_range ? ext(h_q[h_sel], sgn_q) : '0;
        // Low AW bits of the product are exact for both signed and unsigned.
        prod       = a_ext * h_ext;
        sum        = acc_q + prod;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        a_d       = a_q;
        h_d       = h_q;
        sgn_d     = sgn_q;
        i_d       = i_q;
        n_d       = n_q;
        fin_d     = fin_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        y_idx_d   = y_idx_q;
        y_valid_d = 1'b0;

        if (accept) begin
            for (int k = 0; k < K; k++) begin
                a_d[k] = a_vec[k*DW +: DW];
                h_d[k] = h_vec[k*DW +: DW];
            end
            sgn_d = signed_mode;
            i_d   = '0;
            n_d   = '0;
            fin_d = 1'b0;
            acc_d = '0;
        end else if (state_q == S_RUN && !fin_q) begin
            if (i_q == I_LAST) begin
                y_out_d   = sum;
                y_idx_d   = n_q;
                y_valid_d = 1'b1;
                acc_d     = '0;
                i_d       = '0;
                if (n_q == N_LAST) begin
                    fin_d = 1'b1;
                end else begin
                    n_d = n_q + IW'(1);
                end
            end else begin
                acc_d = sum;
                i_d   = i_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                a_q[k] <= '0;
                h_q[k] <= '0;
            end
            sgn_q     <= 1'b0;
            i_q       <= '0;
            n_q       <= '0;
            fin_q     <= 1'b0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_idx_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            h_q       <= h_d;
            sgn_q     <= sgn_d;
            i_q       <= i_d;
            n_q       <= n_d;
            fin_q     <= fin_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_idx_q   <= y_idx_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_idx   = y_idx_q;
    assign y_valid = y_valid_q;

endmodule
